// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: FSM states, instruction classes, opcodes, control codes.
// Pure declarations: no latency; no flow control.
package legv8_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CLS_LDUR,
        CLS_STUR,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B,
        CLS_NONE
    } cls_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [1:0] IMM_D  = 2'b00;
    localparam logic [1:0] IMM_CB = 2'b01;
    localparam logic [1:0] IMM_I  = 2'b10;
    localparam logic [1:0] IMM_B  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

endpackage

// File: rtl/legv8_opdecode.sv
// Classifies the instruction word into an execution class and flags unknown opcodes.
// Combinational, zero latency; no flow control.
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic        illegal
);

    // Longest opcode fields are tested first so shorter prefixes cannot shadow them.
    always_comb begin
        cls = CLS_NONE;
        if (instr[31:21] == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (instr[31:21] == OP_STUR) begin
            cls = CLS_STUR;
        end else if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
                     instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
            cls = CLS_RTYPE;
        end else if (instr[31:22] == OP_ADDI) begin
            cls = CLS_ADDI;
        end else if (instr[31:24] == OP_CBZ) begin
            cls = CLS_CBZ;
        end else if (instr[31:24] == OP_CBNZ) begin
            cls = CLS_CBNZ;
        end else if (instr[31:26] == OP_B) begin
            cls = CLS_B;
        end
    end

    assign illegal = (cls == CLS_NONE);

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM with memory-wait timeout and retired-instruction counter.
// 3-5 cycles per instruction plus memory wait; stalls in FETCH/MEM until mem_ack or timeout.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             pc_src,
    output logic [1:0]       imm_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    cls_t              cls_q, dec_cls;
    logic              dec_illegal;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q, set_err, retire, timeout, taken;
    logic [CNT_W-1:0]  retired_q;

    legv8_opdecode u_opdecode (
        .instr   (instr),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // The last permitted wait cycle still accepts an ack; only a missing ack times out.
    assign timeout = !mem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 1'b0;
        imm_sel    = IMM_D;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        set_err    = 1'b0;
        retire     = 1'b0;
        taken      = 1'b0;
        // Holding rst_n low keeps every strobe quiet even though the state reads FETCH.
        if (rst_n) begin
            unique case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (timeout) begin
                        set_err = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        set_err = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    unique case (cls_q)
                        CLS_RTYPE: begin
                            alu_op  = ALU_RTYPE;
                            state_d = ST_WB;
                        end
                        CLS_ADDI: begin
                            imm_sel = IMM_I;
                            alu_src = 1'b1;
                            state_d = ST_WB;
                        end
                        CLS_LDUR, CLS_STUR: begin
                            imm_sel = IMM_D;
                            alu_src = 1'b1;
                            state_d = ST_MEM;
                        end
                        CLS_CBZ, CLS_CBNZ: begin
                            taken    = (cls_q == CLS_CBZ) ? zero : !zero;
                            imm_sel  = IMM_CB;
                            alu_op   = ALU_PASSB;
                            pc_write = taken;
                            pc_src   = taken;
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        CLS_B: begin
                            imm_sel  = IMM_B;
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        default: begin
                            set_err = 1'b1;
                            state_d = ST_ERROR;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_read  = (cls_q == CLS_LDUR);
                    mem_write = (cls_q == CLS_STUR);
                    if (mem_ack) begin
                        if (cls_q == CLS_LDUR) begin
                            state_d = ST_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else if (timeout) begin
                        set_err = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == CLS_LDUR);
                    retire     = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            wait_q    <= '0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec_cls;
            end
            // Staying in FETCH/MEM implies no ack this cycle; any state change restarts the count.
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
                wait_q <= wait_q + 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign err     = err_q | set_err;
    assign retired = retired_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Random and directed instruction episodes checked cycle by cycle against a
// transaction-level model built from the instruction-class rules.
module tb_legv8_multicycle_ctrl;

    localparam int MAXW = 15;
    localparam int CW   = 4;

    localparam int K_ILL  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_R    = 3;
    localparam int K_ADDI = 4;
    localparam int K_CBZ  = 5;
    localparam int K_CBNZ = 6;
    localparam int K_B    = 7;

    typedef struct packed {
        logic       err;
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       pc_src;
        logic [1:0] imm_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_to_reg;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr = '0;
    logic          zero = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_read, mem_write, iord;
    logic          ir_write, pc_write, reg_write, pc_src;
    logic [1:0]    imm_sel, alu_op;
    logic          alu_src, mem_to_reg, err;
    logic [CW-1:0] retired;

    int            n_chk = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_ret = '0;
    obs_t          exp_q[$];
    bit            ack_q[$];

    legv8_multicycle_ctrl #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .imm_sel    (imm_sel),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = {err, mem_req, mem_read, mem_write, iord, ir_write, pc_write,
             reg_write, pc_src, imm_sel, alu_src, alu_op, mem_to_reg};
        return o;
    endfunction

    function automatic int classify(input logic [31:0] w);
        logic [10:0] o11;
        o11 = w[31:21];
        if (o11 == 11'b11111000010) return K_LD;
        if (o11 == 11'b11111000000) return K_ST;
        if (o11 == 11'b10001011000 || o11 == 11'b11001011000 ||
            o11 == 11'b10001010000 || o11 == 11'b10101010000) return K_R;
        if (w[31:22] == 10'b1001000100) return K_ADDI;
        if (w[31:24] == 8'b10110100) return K_CBZ;
        if (w[31:24] == 8'b10110101) return K_CBNZ;
        if (w[31:26] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [31:0] make_instr(input int k);
        logic [31:0] r;
        logic [10:0] rop [4];
        r = $urandom;
        rop = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        case (k)
            K_LD:    return {11'b11111000010, r[20:0]};
            K_ST:    return {11'b11111000000, r[20:0]};
            K_R:     return {rop[$urandom_range(0, 3)], r[20:0]};
            K_ADDI:  return {10'b1001000100, r[21:0]};
            K_CBZ:   return {8'b10110100, r[23:0]};
            K_CBNZ:  return {8'b10110101, r[23:0]};
            K_B:     return {6'b000101, r[25:0]};
            default: return r;
        endcase
    endfunction

    function automatic void push(input obs_t o, input bit a);
        exp_q.push_back(o);
        ack_q.push_back(a);
    endfunction

    function automatic obs_t wb(input bit from_mem);
        obs_t o;
        o = '0;
        o.reg_write  = 1'b1;
        o.mem_to_reg = from_mem;
        return o;
    endfunction

    // A memory phase answers on its (w+1)-th cycle; w >= MAXW means it never does.
    function automatic bit wait_phase(input obs_t wait_o, input obs_t ack_o, input int w);
        obs_t o;
        for (int i = 0; i < MAXW; i++) begin
            if (i == w) begin
                push(ack_o, 1'b1);
                return 1'b0;
            end
            o = wait_o;
            if (i == MAXW - 1) begin
                o.err = 1'b1;
                push(o, 1'b0);
                return 1'b1;
            end
            push(o, 1'b0);
        end
        return 1'b1;
    endfunction

    // Starts at posedge+1 of a FETCH cycle; cut >= 0 stops after that many cycles.
    task automatic episode(input logic [31:0] ins, input int fw, input int mw,
                           input bit z, input int cut, output bit dead);
        obs_t w_o, a_o, o, e;
        int   k, n;
        bit   ret;
        exp_q.delete();
        ack_q.delete();
        ret = 1'b0;
        k = classify(ins);
        w_o = '0;
        w_o.mem_req  = 1'b1;
        w_o.mem_read = 1'b1;
        a_o = w_o;
        a_o.ir_write = 1'b1;
        a_o.pc_write = 1'b1;
        dead = wait_phase(w_o, a_o, fw);
        if (!dead) begin
            o = '0;
            if (k == K_ILL) begin
                o.err = 1'b1;
                push(o, 1'b0);
                dead = 1'b1;
            end else begin
                push(o, 1'b0);
                case (k)
                    K_R: begin
                        o.alu_op = 2'b10;
                        push(o, 1'b0);
                        push(wb(1'b0), 1'b0);
                        ret = 1'b1;
                    end
                    K_ADDI: begin
                        o.imm_sel = 2'b10;
                        o.alu_src = 1'b1;
                        push(o, 1'b0);
                        push(wb(1'b0), 1'b0);
                        ret = 1'b1;
                    end
                    K_CBZ, K_CBNZ: begin
                        o.imm_sel  = 2'b01;
                        o.alu_op   = 2'b01;
                        o.pc_write = (k == K_CBZ) ? z : !z;
                        o.pc_src   = o.pc_write;
                        push(o, 1'b0);
                        ret = 1'b1;
                    end
                    K_B: begin
                        o.imm_sel  = 2'b11;
                        o.pc_write = 1'b1;
                        o.pc_src   = 1'b1;
                        push(o, 1'b0);
                        ret = 1'b1;
                    end
                    default: begin
                        o.alu_src = 1'b1;
                        push(o, 1'b0);
                        w_o = '0;
                        w_o.mem_req   = 1'b1;
                        w_o.iord      = 1'b1;
                        w_o.mem_read  = (k == K_LD);
                        w_o.mem_write = (k == K_ST);
                        dead = wait_phase(w_o, w_o, mw);
                        if (!dead) begin
                            if (k == K_LD) push(wb(1'b1), 1'b0);
                            ret = 1'b1;
                        end
                    end
                endcase
            end
        end
        instr = ins;
        zero  = z;
        n = (cut >= 0 && cut < exp_q.size()) ? cut : exp_q.size();
        for (int i = 0; i < n; i++) begin
            mem_ack = ack_q[i];
            @(negedge clk);
            check_eq("cycle", 32'(sample()), 32'(exp_q[i]));
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        if (cut < 0) begin
            if (dead) begin
                e = '0;
                e.err = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    mem_ack = 1'b1;
                    @(negedge clk);
                    check_eq("error_idle", 32'(sample()), 32'(e));
                    @(posedge clk);
                    #1;
                end
                mem_ack = 1'b0;
            end
            if (ret) exp_ret = exp_ret + 1'b1;
            check_eq("retired", 32'(retired), 32'(exp_ret));
        end
    endtask

    task automatic do_reset();
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs", 32'(sample()), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    initial begin
        bit   dead;
        int   k, fw, mw;
        logic [31:0] ins;

        do_reset();
        episode(32'h8B020020, 0, 0, 1'b0, -1, dead);
        episode(32'hF8408041, 0, 3, 1'b0, -1, dead);
        episode(32'hB4000040, 0, 0, 1'b1, -1, dead);
        episode(32'hB4000040, 0, 0, 1'b0, -1, dead);
        episode(32'hB5000040, 1, 0, 1'b0, -1, dead);
        episode(32'hB5000040, 0, 0, 1'b1, -1, dead);
        episode(32'h14000003, 2, 0, 1'b0, -1, dead);
        episode(32'h91000421, 0, 0, 1'b0, -1, dead);
        episode(32'hF8000041, 3, 2, 1'b0, -1, dead);
        episode(32'hF8408041, 14, 14, 1'b0, -1, dead);

        episode(32'h8B020020, 15, 0, 1'b0, -1, dead);
        do_reset();
        episode(32'hF8000041, 0, 15, 1'b0, -1, dead);
        do_reset();
        episode(32'h00000000, 0, 0, 1'b0, -1, dead);
        do_reset();
        episode(32'hF8000041, 0, 6, 1'b0, 5, dead);
        do_reset();
        episode(32'h8B020020, 0, 0, 1'b0, -1, dead);

        for (int t = 0; t < 150; t++) begin
            k   = $urandom_range(0, 7);
            ins = (k == K_ILL && $urandom_range(0, 1) == 0) ? 32'h0 : make_instr(k);
            fw  = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 4);
            mw  = ($urandom_range(0, 3) == 0) ? $urandom_range(MAXW - 3, MAXW)
                                              : $urandom_range(0, 4);
            episode(ins, fw, mw, 1'($urandom_range(0, 1)), -1, dead);
            if (dead) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
LEGV8_MULTICYCLE_CTRL -- requirements
Module: legv8_multicycle_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles a memory request may wait for mem_ack before the block flags a timeout.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr  input  32  current instruction register contents.
REQ-006 zero  input  1  ALU zero flag, valid in EXEC.
REQ-007 mem_ack  input  1  memory completion strobe for the current mem_req.
REQ-008 mem_req, mem_read, mem_write, iord  output  1 each  memory request; read/write qualifier; 0 = instruction address, 1 = data address.
REQ-009 ir_write, pc_write, reg_write  output  1 each  single-cycle write enables.
REQ-010 pc_src  output  1  0 = PC+4, 1 = PC + (sign-extended offset << 2).
REQ-011 imm_sel  output  2  immediate format for the sign extender: 00 D-type [20:12], 01 CB-type [23:5], 10 I-type [21:10], 11 B-type [25:0].
REQ-012 alu_src  output  1  0 = register, 1 = extended immediate.
REQ-013 alu_op  output  2  00 add, 01 pass-B/zero-test, 10 R-type funct decode.
REQ-014 mem_to_reg  output  1  write-back source select: 1 = memory.
REQ-015 err  output  1  sticky error: illegal opcode or memory timeout.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 States SHALL be FETCH, DECODE, EXEC, MEM, WB and ERROR; all outputs SHALL be decoded from state, with ir_write and pc_write additionally gated by mem_ack in FETCH.
REQ-018 FETCH SHALL assert mem_req=1, mem_read=1, iord=0 until mem_ack; in the ack cycle it SHALL pulse ir_write and pc_write with pc_src=0, then go to DECODE.
REQ-019 DECODE SHALL last 1 cycle and latch the instruction class from instr: LDUR [31:21]=11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDI [31:22]=1001000100, CBZ [31:24]=10110100, CBNZ 10110101, B [31:26]=000101.
REQ-020 An unmatched opcode in DECODE SHALL set err and enter ERROR; ERROR SHALL be absorbing until reset, with all enables 0.
REQ-021 EXEC behaviour by class: R-type alu_op=10, alu_src=0, then WB. ADDI imm_sel=10, alu_src=1, alu_op=00, then WB. LDUR/STUR imm_sel=00, alu_src=1, alu_op=00, then MEM.
REQ-022 CBZ/CBNZ in EXEC SHALL use imm_sel=01 and alu_op=01, and SHALL pulse pc_write with pc_src=1 iff zero=1 (CBZ) or zero=0 (CBNZ); either way the next state is FETCH and retired increments.
REQ-023 B in EXEC SHALL use imm_sel=11, pulse pc_write with pc_src=1, increment retired, and go to FETCH.
REQ-024 MEM SHALL assert mem_req=1 and iord=1, with mem_read=1 for LDUR or mem_write=1 for STUR, until mem_ack; then LDUR goes to WB and STUR goes to FETCH, with retired incremented.
REQ-025 WB SHALL pulse reg_write, with mem_to_reg=1 only for LDUR, increment retired, and go to FETCH.
REQ-026 Latency from the fetch ack cycle: R/ADDI 3 cycles, B/CB 2, STUR 2+mem wait, LDUR 3+mem wait.
REQ-027 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without mem_ack; reaching MAX_WAIT without ack SHALL set err and enter ERROR.
REQ-028 mem_ack outside FETCH or MEM SHALL be ignored; an ack in the same cycle the count reaches MAX_WAIT SHALL win, and no error is raised.
REQ-029 retired SHALL wrap modulo 2^CNT_W.
REQ-030 mem_req SHALL never be asserted with mem_read and mem_write both 1.

Reset
REQ-031 While rst_n=0, the state SHALL be FETCH, err=0, retired=0 and the wait counter=0, and all enables and requests SHALL be 0.
REQ-032 Assertion of rst_n mid-instruction, including mid-MEM, SHALL abort immediately, with no write pulse completing.
REQ-033 The first mem_req SHALL be issued in the first clk edge after rst_n deasserts.

Structure
REQ-034 State encoding, class enumeration, opcode constants and the imm_sel/alu_op codes SHALL live in the shared package legv8_pkg.
REQ-035 Opcode classification SHALL be the sub-module legv8_opdecode (combinational instr to class + illegal); the FSM, wait counter and retired counter stay in the top.

Verification
REQ-036 ADD 0x8B020020, ack in the first FETCH cycle: ir_write/pc_write in cycle 0, alu_op=10 in cycle 2, reg_write in cycle 3, retired=1.
REQ-037 LDUR 0xF8408041, MEM ack after 3 cycles: imm_sel=00, MEM held for 4 cycles, then WB with mem_to_reg=1.
REQ-038 CBZ 0xB4000040 with zero=1 gives pc_write=1, pc_src=1; repeating with zero=0 gives no pc_write, and retired increments both times.
REQ-039 Fetch with no ack for 15 cycles: err=1, state ERROR, outputs idle; an ack arriving later is ignored.
REQ-040 Illegal instr 0x00000000 gives err in the DECODE cycle; then rst_n pulsed low mid-MEM of a STUR gives no mem_write after reset, with state FETCH.
